// File: rtl/multicycle_control_if.sv
// Handshake and control bundle between fetch/memory (master) and the
// multi-cycle controller (slave).
interface multicycle_control_if #(
    parameter int OPCODE_W = 6
) ();
    logic [OPCODE_W-1:0] opcode;
    logic                op_valid;
    logic                op_ready;
    logic                mem_ready;
    logic                RegWrite;
    logic [1:0]          ALUOp;
    logic                RegDst;
    logic                ALUSrc;
    logic                MemWrite;
    logic                MemRead;
    logic                MemtoReg;
    logic                Branch;
    logic                illegal;
    logic                mem_err;

    modport master (
        output opcode, op_valid, mem_ready,
        input  op_ready, RegWrite, ALUOp, RegDst, ALUSrc,
        input  MemWrite, MemRead, MemtoReg, Branch, illegal, mem_err
    );

    modport slave (
        input  opcode, op_valid, mem_ready,
        output op_ready, RegWrite, ALUOp, RegDst, ALUSrc,
        output MemWrite, MemRead, MemtoReg, Branch, illegal, mem_err
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle instruction controller: IDLE -> DECODE -> EXEC -> (MEM) -> WB.
// Datapath controls are decoded from the current state and the opcode latched
// at accept time. MEM waits on mem_ready with a bounded timeout.
// Optional feature macro: CTRL_BRANCH_EN (adds BEQ with a one-cycle Branch
// strobe in EXEC; without it opcode 5 is illegal and Branch is constant 0).
module multicycle_control #(
    parameter int OPCODE_W    = 6,
    parameter int OP_RTYPE    = 4,
    parameter int OP_ADDIU    = 12,
    parameter int OP_SUBIU    = 13,
    parameter int OP_SW       = 16,
    parameter int OP_LW       = 17,
`ifdef CTRL_BRANCH_EN
    parameter int OP_BEQ      = 5,
`endif
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.slave  bus
);
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    state_t              state_q, state_d;
    logic [OPCODE_W-1:0] opcode_q, opcode_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic is_rtype, is_addiu, is_subiu, is_sw, is_lw, is_beq, supported, timed_out;

    // Classify the latched opcode once; everything downstream uses these flags.
    always_comb begin
        is_rtype  = (opcode_q == OPCODE_W'(OP_RTYPE));
        is_addiu  = (opcode_q == OPCODE_W'(OP_ADDIU));
        is_subiu  = (opcode_q == OPCODE_W'(OP_SUBIU));
        is_sw     = (opcode_q == OPCODE_W'(OP_SW));
        is_lw     = (opcode_q == OPCODE_W'(OP_LW));
`ifdef CTRL_BRANCH_EN
        is_beq    = (opcode_q == OPCODE_W'(OP_BEQ));
`else
        is_beq    = 1'b0;
`endif
        supported = is_rtype | is_addiu | is_subiu | is_sw | is_lw | is_beq;
        // Counter holds the 1-based index of the current MEM cycle.
        timed_out = (cnt_q == CNT_W'(MEM_TIMEOUT));
    end

    // State, opcode latch and MEM cycle counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            opcode_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic; counter is loaded with 1 on MEM entry and cleared on exit.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.op_valid) begin
                    opcode_d = bus.opcode;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: state_d = supported ? S_EXEC : S_IDLE;
            S_EXEC: begin
                if (is_sw || is_lw) begin
                    state_d = S_MEM;
                    cnt_d   = CNT_W'(1);
                end else if (is_beq) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                // A ready on the final allowed cycle still completes normally.
                if (bus.mem_ready) begin
                    state_d = is_lw ? S_WB : S_IDLE;
                    cnt_d   = '0;
                end else if (timed_out) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Phase-decoded datapath controls; everything is 0 outside its phase.
    always_comb begin
        bus.op_ready = 1'b0;
        bus.RegWrite = 1'b0;
        bus.ALUOp    = 2'b00;
        bus.RegDst   = 1'b0;
        bus.ALUSrc   = 1'b0;
        bus.MemWrite = 1'b0;
        bus.MemRead  = 1'b0;
        bus.MemtoReg = 1'b0;
        bus.Branch   = 1'b0;
        bus.illegal  = 1'b0;
        bus.mem_err  = 1'b0;
        case (state_q)
            S_IDLE:   bus.op_ready = 1'b1;
            S_DECODE: bus.illegal  = ~supported;
            S_EXEC: begin
                bus.ALUOp  = is_rtype ? 2'b10 : ((is_subiu || is_beq) ? 2'b00 : 2'b01);
                bus.ALUSrc = ~(is_rtype | is_beq);
`ifdef CTRL_BRANCH_EN
                bus.Branch = is_beq;
`endif
            end
            S_MEM: begin
                // Only loads and stores reach MEM, both using base + offset.
                bus.ALUOp    = 2'b01;
                bus.ALUSrc   = 1'b1;
                bus.MemRead  = is_lw;
                bus.MemWrite = is_sw;
                bus.mem_err  = timed_out & ~bus.mem_ready;
            end
            S_WB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = is_rtype;
                bus.MemtoReg = is_lw;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. For every instruction a
// behavioural model lists the expected control vector for each cycle from
// accept until the controller is idle again, and the bench compares the DUT
// against it cycle by cycle while driving random noise on ignored inputs.
module tb_multicycle_control;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_if #(.OPCODE_W(6)) bus ();

    multicycle_control #(.MEM_TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       op_ready;
        logic       RegWrite;
        logic [1:0] ALUOp;
        logic       RegDst;
        logic       ALUSrc;
        logic       MemWrite;
        logic       MemRead;
        logic       MemtoReg;
        logic       Branch;
        logic       illegal;
        logic       mem_err;
    } ctrl_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    ctrl_t exp_q[$];
    logic  mr_q[$];

    function automatic ctrl_t idle_v();
        ctrl_t c = '0;
        c.op_ready = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t observe();
        ctrl_t c;
        c.op_ready = bus.op_ready;
        c.RegWrite = bus.RegWrite;
        c.ALUOp    = bus.ALUOp;
        c.RegDst   = bus.RegDst;
        c.ALUSrc   = bus.ALUSrc;
        c.MemWrite = bus.MemWrite;
        c.MemRead  = bus.MemRead;
        c.MemtoReg = bus.MemtoReg;
        c.Branch   = bus.Branch;
        c.illegal  = bus.illegal;
        c.mem_err  = bus.mem_err;
        return c;
    endfunction

    task automatic check(input string tag, input ctrl_t expv);
        ctrl_t obs;
        obs = observe();
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Behavioural model: per-cycle expectations after accepting 'op', where
    // memory answers on MEM cycle number 'lat' (never if lat > TO).
    task automatic build_model(input int op, input int lat);
        ctrl_t c;
        bit    is_beq, alu, mem, ok;
        int    n;
        exp_q.delete();
        mr_q.delete();
`ifdef CTRL_BRANCH_EN
        is_beq = (op == 5);
`else
        is_beq = 1'b0;
`endif
        alu = (op == 4) || (op == 12) || (op == 13);
        mem = (op == 16) || (op == 17);
        ok  = alu || mem || is_beq;
        // DECODE
        c = '0;
        c.illegal = !ok;
        exp_q.push_back(c); mr_q.push_back(1'($urandom));
        if (ok) begin
            // EXEC
            c = '0;
            c.ALUOp  = (op == 4) ? 2'b10 : ((op == 13 || is_beq) ? 2'b00 : 2'b01);
            c.ALUSrc = !(op == 4 || is_beq);
            c.Branch = is_beq;
            exp_q.push_back(c); mr_q.push_back(1'($urandom));
            if (mem) begin
                n = (lat <= TO) ? lat : TO;
                for (int k = 1; k <= n; k++) begin
                    c = '0;
                    c.ALUOp    = 2'b01;
                    c.ALUSrc   = 1'b1;
                    c.MemRead  = (op == 17);
                    c.MemWrite = (op == 16);
                    c.mem_err  = (k == TO) && (lat > TO);
                    exp_q.push_back(c); mr_q.push_back(k == lat);
                end
            end
            if (alu || (op == 17 && lat <= TO)) begin
                c = '0;
                c.RegWrite = 1'b1;
                c.RegDst   = (op == 4);
                c.MemtoReg = (op == 17);
                exp_q.push_back(c); mr_q.push_back(1'($urandom));
            end
        end
        exp_q.push_back(idle_v()); mr_q.push_back(1'($urandom));
    endtask

    task automatic run_instr(input string tag, input int op, input int lat);
        @(posedge clk); #1;
        bus.opcode    = 6'(op);
        bus.op_valid  = 1'b1;
        bus.mem_ready = 1'($urandom);
        #1 check($sformatf("%s op=%0d accept", tag, op), idle_v());
        build_model(op, lat);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk); #1;
            // Busy-phase op_valid/opcode are noise the controller must ignore.
            bus.op_valid  = (i == exp_q.size() - 1) ? 1'b0 : 1'($urandom);
            bus.opcode    = 6'($urandom);
            bus.mem_ready = mr_q[i];
            #1 check($sformatf("%s op=%0d lat=%0d cyc=T+%0d", tag, op, lat, i + 1), exp_q[i]);
        end
        $display("[TB] %s op=%0d lat=%0d cycles=%0d", tag, op, lat, exp_q.size());
    endtask

    initial begin
        ctrl_t memv;
        int    op, lat, sel;

        bus.opcode    = '0;
        bus.op_valid  = 1'b0;
        bus.mem_ready = 1'b0;

        // Reset held for two cycles.
        repeat (2) @(posedge clk);
        #1 check("reset", idle_v());
        rst = 1'b0;
        $display("[TB] reset released");

        // Directed cases.
        run_instr("rtype",        4, 1);
        run_instr("addiu",       12, 1);
        run_instr("subiu",       13, 1);
        run_instr("lw_lat3",     17, 3);
        run_instr("lw_lat1",     17, 1);
        run_instr("sw_timeout",  16, 99);
        run_instr("lw_timeout",  17, 16);
        run_instr("sw_edge",     16, TO);
        run_instr("sw_lat1",     16, 1);
        run_instr("illegal9",     9, 1);
        run_instr("op5",          5, 1);

        // Reset in the middle of a load's MEM phase.
        @(posedge clk); #1;
        bus.opcode = 6'd17; bus.op_valid = 1'b1;
        @(posedge clk); #1;                      // DECODE
        bus.op_valid = 1'b0;
        @(posedge clk); #1;                      // EXEC: stray op_valid ignored
        bus.op_valid = 1'b1; bus.opcode = 6'd4;
        @(posedge clk); #1;                      // MEM cycle 1
        bus.op_valid = 1'b0; bus.mem_ready = 1'b0;
        memv = '0; memv.ALUOp = 2'b01; memv.ALUSrc = 1'b1; memv.MemRead = 1'b1;
        #1 check("rst_mid lw mem1", memv);
        rst = 1'b1; bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus.mem_ready = 1'b0;
        #1 check("rst_mid after_rst", idle_v());
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            check($sformatf("rst_mid idle%0d", i), idle_v());
        end
        $display("[TB] rst_mid lw aborted");

        // Randomized instruction mix.
        for (int n = 0; n < 50; n++) begin
            sel = int'($urandom_range(0, 7));
            case (sel)
                0: op = 4;
                1: op = 12;
                2: op = 13;
                3: op = 16;
                4: op = 17;
                5: op = 5;
                6: op = int'($urandom_range(0, 63));
                default: op = 17;
            endcase
            lat = int'($urandom_range(1, 20));
            run_instr($sformatf("rand%0d", n), op, lat);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
